// File: rtl/multdiv_defs.sv
// Shared definitions for the multiply/divide unit: FSM encodings, decode opcodes
// and default sizes.
package multdiv_defs;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } md_state_e;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Decode helper: returns {ctrl_MULT, ctrl_DIV} for an ALU opcode.
    function automatic logic [1:0] decode_ctrl(input logic [4:0] op);
        decode_ctrl = {op == ALU_MUL, op == ALU_DIV};
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide unit; flags done once WIDTH steps
// have been taken.
module multdiv_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: the reset is synchronous, so it lives inside the clocked branch; all state
    // uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done_o = (count_q == CNT_W'(WIDTH));

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide: magnitude shift-add / restoring divide over
// WIDTH steps, sign and exceptions applied on the final edge.
module multdiv_unit
    import multdiv_defs::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic               neg_q, div_zero_q, div_ovf_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d, rdy_q;

    logic               start, running, cnt_done;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [2*WIDTH-1:0] shifted, prod_s;
    logic [WIDTH:0]     add_a, add_b, add_y;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quot_s;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign running  = (state_q == MULT_RUN) || (state_q == DIV_RUN);
    assign in_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign in_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (start),
        .en_i   (running && !cnt_done),
        .done_o (cnt_done)
    );

    // One adder serves both ops: add multiplicand into the high word, or trial-subtract
    // the divisor from the left-shifted partial remainder.
    assign shifted = {acc_q[2*WIDTH-2:0], 1'b0};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        add_b = {1'b0, mag_a_q};
        add_y = add_a + add_b;
        acc_d = acc_q;
        if (state_q == DIV_RUN) begin
            add_a = {1'b0, shifted[2*WIDTH-1:WIDTH]};
            add_b = {1'b0, mag_b_q};
            add_y = add_a - add_b;
            if (!add_y[WIDTH]) acc_d = {add_y[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            else               acc_d = shifted;
        end else if (acc_q[0]) begin
            acc_d = {add_y, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    assign prod_s   = neg_q ? -acc_q : acc_q;
    assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    assign quot_s   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        result_d = quot_s;
        exc_d    = 1'b0;
        if (state_q == MULT_RUN) begin
            result_d = prod_s[WIDTH-1:0];
            exc_d    = !((&prod_top) || !(|prod_top));
        end else if (div_zero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
        end else if (div_ovf_q) begin
            result_d = MIN_WORD;
            exc_d    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                state_q    <= ctrl_MULT ? MULT_RUN : DIV_RUN;
                mag_a_q    <= in_mag_a;
                mag_b_q    <= in_mag_b;
                neg_q      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_q <= (data_operandB == '0);
                div_ovf_q  <= (data_operandA == MIN_WORD) && (&data_operandB);
                acc_q      <= ctrl_MULT ? {{WIDTH{1'b0}}, in_mag_b} : {{WIDTH{1'b0}}, in_mag_a};
            end else begin
                case (state_q)
                    MULT_RUN, DIV_RUN: begin
                        if (!cnt_done) begin
                            acc_q <= acc_d;
                        end else begin
                            result_q <= result_d;
                            exc_q    <= exc_d;
                            rdy_q    <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: vector table through a scoreboard queue, plus restart,
// simultaneous-start and mid-op reset sequences.
module tb_multdiv_unit;
    import multdiv_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_count = 0;

    always @(negedge clock) if (data_resultRDY === 1'b1) rdy_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic exc);
        exp_t e;
        e.res = res;
        e.exc = exc;
        exp_q.push_back(e);
    endtask

    // Drives the start pulse so that it is sampled at the next rising edge (E0).
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int   edges = 0;
        bit   seen  = 0;
        exp_t e;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            #1;
            edges++;
            if (data_resultRDY === 1'b1) seen = 1;
        end
        if (!seen) edges = -1;
        check({name, "_latency"}, 32'(edges), 32'(exp_edges));
        if (seen) begin
            check({name, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({name, "_result"}, data_result, e.res);
                check({name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
            end
            @(posedge clock);
            #1;
            check({name, "_rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [1:0]  ctl;
        int          base;
        logic [31:0] last_res;

        vecs = '{
            '{ALU_MUL, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
            '{ALU_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1},
            '{ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
            '{ALU_MUL, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0},
            '{ALU_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
            '{ALU_MUL, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1},
            '{ALU_MUL, 32'hFFFF8000, 32'h00010000, 32'h80000000, 1'b0},
            '{ALU_MUL, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{ALU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
            '{ALU_DIV, 32'd100,      32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0},
            '{ALU_DIV, 32'd5,        32'd0,        32'h00000000, 1'b1},
            '{ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
            '{ALU_DIV, 32'd1000,     32'd7,        32'h0000008E, 1'b0},
            '{ALU_DIV, 32'hFFFFFC18, 32'd7,        32'hFFFFFF72, 1'b0},
            '{ALU_DIV, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0},
            '{ALU_DIV, 32'd3,        32'h80000000, 32'h00000000, 1'b0},
            '{ALU_DIV, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0}
        };

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            ctl = decode_ctrl(vecs[i].op);
            push_exp(vecs[i].res, vecs[i].exc);
            start_op(ctl[1], ctl[0], vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 33);
        end

        // Idle: outputs hold and no strobe appears without a start.
        last_res = vecs[vecs.size()-1].res;
        base = rdy_count;
        repeat (6) @(posedge clock);
        #1;
        check("idle_no_rdy", 32'(rdy_count - base), 32'd0);
        check("idle_hold_result", data_result, last_res);

        // Restart: mult 3*4 aborted by div 20/4 at edge 10.
        base = rdy_count;
        push_exp(32'd12, 1'b0);
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        exp_q.delete();
        push_exp(32'd5, 1'b0);
        wait_done("restart", 33);
        check("restart_single_rdy", 32'(rdy_count - base), 32'd1);

        // Both starts together: multiply takes priority.
        push_exp(32'd18, 1'b0);
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done("simul", 33);

        // Reset in the middle of a divide.
        push_exp(32'd14, 1'b0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        base = rdy_count;
        repeat (40) @(posedge clock);
        #1;
        check("midreset_no_rdy", 32'(rdy_count - base), 32'd0);
        push_exp(32'd81, 1'b0);
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        wait_done("post_reset", 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
